// File: rtl/mux_rr_n.sv
// Registered CH-channel arbitrating mux with valid/ready on every port.
// Selects one requester per cycle (round-robin or fixed priority) into a single output register.
module mux_rr_n #(
   parameter int N    = 32,
   parameter int CH   = 4,
   parameter int SELW = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fixed_pri,
   input  logic [CH-1:0]     in_valid,
   input  logic [CH*N-1:0]   in_data,
   output logic [CH-1:0]     in_ready,
   output logic              out_valid,
   output logic [N-1:0]      out_data,
   output logic [SELW-1:0]   out_sel,
   input  logic              out_ready
);

   logic [SELW-1:0] ptr;
   logic [SELW-1:0] grant;
   logic            grant_valid;
   logic [SELW-1:0] idx;
   logic [SELW:0]   sum;
   logic            ld;
   logic [N-1:0]    sel_data;

   assign ld = !out_valid || out_ready;

   // Descending scan with last-hit-wins yields the first requester at or after the start point.
   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      idx         = '0;
      sum         = '0;
      for (int i = CH - 1; i >= 0; i--) begin
         if (fixed_pri) begin
            idx = SELW'(i);
         end else begin
            sum = {1'b0, ptr} + (SELW + 1)'(i);
            if (sum >= (SELW + 1)'(CH)) begin
               sum = sum - (SELW + 1)'(CH);
            end
            idx = sum[SELW-1:0];
         end
         if (in_valid[idx]) begin
            grant       = idx;
            grant_valid = 1'b1;
         end
      end
   end

   always_comb begin
      sel_data = '0;
      in_ready = '0;
      for (int i = 0; i < CH; i++) begin
         if (grant == SELW'(i)) begin
            sel_data    = in_data[i*N +: N];
            in_ready[i] = rst_n && ld && grant_valid;
         end
      end
   end

   // Output register and round-robin pointer; everything holds while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sel   <= '0;
         ptr       <= '0;
      end else if (ld) begin
         if (grant_valid) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_sel   <= grant;
            if (grant == SELW'(CH - 1)) begin
               ptr <= '0;
            end else begin
               ptr <= grant + 1'b1;
            end
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_mux_rr_n.sv
// Directed self-checking bench for mux_rr_n (N=32, CH=4) with hand-computed expectations.
module tb_mux_rr_n;

   localparam int N    = 32;
   localparam int CH   = 4;
   localparam int SELW = 2;

   logic              clk;
   logic              rst_n;
   logic              fixed_pri;
   logic [CH-1:0]     in_valid;
   logic [CH*N-1:0]   in_data;
   logic [CH-1:0]     in_ready;
   logic              out_valid;
   logic [N-1:0]      out_data;
   logic [SELW-1:0]   out_sel;
   logic              out_ready;

   int numChecks = 0;
   int numErrors = 0;

   logic [N-1:0] dWord [CH];

   mux_rr_n #(.N(N), .CH(CH), .SELW(SELW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .fixed_pri (fixed_pri),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [N-1:0] actual, input logic [N-1:0] expected);
      numChecks++;
      if (actual !== expected) begin
         numErrors++;
         $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
      end
   endtask

   // Drive inputs shortly after a rising edge, then let combinational in_ready settle.
   task automatic applyStimulus(input logic fp, input logic [CH-1:0] iv, input logic ordy);
      fixed_pri = fp;
      in_valid  = iv;
      out_ready = ordy;
      in_data   = {dWord[3], dWord[2], dWord[1], dWord[0]};
      #1;
   endtask

   task automatic clockCycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      dWord[0] = 32'hA000_0000;
      dWord[1] = 32'hB111_1111;
      dWord[2] = 32'hC222_2222;
      dWord[3] = 32'hD333_3333;

      // Reset with random inputs
      rst_n     = 1'b0;
      fixed_pri = 1'($urandom);
      in_valid  = 4'($urandom);
      out_ready = 1'($urandom);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      repeat (3) clockCycle();
      in_valid = 4'b1111;
      #1;
      checkOutput("rst_out_valid", N'(out_valid), N'(0));
      checkOutput("rst_out_data", out_data, N'(0));
      checkOutput("rst_out_sel", N'(out_sel), N'(0));
      checkOutput("rst_in_ready", N'(in_ready), N'(0));

      // Round-robin with all channels requesting
      rst_n = 1'b1;
      applyStimulus(1'b0, 4'b1111, 1'b1);
      checkOutput("rr_first_ready", N'(in_ready), N'(4'b0001));
      for (int k = 0; k < 8; k++) begin
         clockCycle();
         checkOutput("rr_valid", N'(out_valid), N'(1));
         checkOutput("rr_sel", N'(out_sel), N'(k % 4));
         checkOutput("rr_data", out_data, dWord[k % 4]);
         checkOutput("rr_ready", N'(in_ready), N'(4'b0001 << ((k + 1) % 4)));
      end

      // Fixed priority, then back to round-robin from pointer 2
      applyStimulus(1'b1, 4'b1010, 1'b1);
      for (int k = 0; k < 3; k++) begin
         clockCycle();
         checkOutput("fp_sel", N'(out_sel), N'(1));
         checkOutput("fp_data", out_data, dWord[1]);
      end
      applyStimulus(1'b0, 4'b1010, 1'b1);
      checkOutput("sw_ready3", N'(in_ready), N'(4'b1000));
      clockCycle();
      checkOutput("sw_sel3", N'(out_sel), N'(3));
      checkOutput("sw_ready1", N'(in_ready), N'(4'b0010));
      clockCycle();
      checkOutput("sw_sel1", N'(out_sel), N'(1));

      // Backpressure holding 0xDEADBEEF
      dWord[0] = 32'hDEAD_BEEF;
      applyStimulus(1'b0, 4'b0001, 1'b1);
      clockCycle();
      checkOutput("bp_load", out_data, 32'hDEAD_BEEF);
      dWord[0] = 32'hA000_0000;
      applyStimulus(1'b0, 4'b0100, 1'b0);
      for (int k = 0; k < 5; k++) begin
         checkOutput("bp_ready", N'(in_ready), N'(0));
         clockCycle();
         checkOutput("bp_valid", N'(out_valid), N'(1));
         checkOutput("bp_data", out_data, 32'hDEAD_BEEF);
         checkOutput("bp_sel", N'(out_sel), N'(0));
      end
      applyStimulus(1'b0, 4'b0100, 1'b1);
      checkOutput("bp_release_ready", N'(in_ready), N'(4'b0100));
      clockCycle();
      checkOutput("bp_reload_valid", N'(out_valid), N'(1));
      checkOutput("bp_reload_sel", N'(out_sel), N'(2));
      checkOutput("bp_reload_data", out_data, dWord[2]);

      // Drain to empty
      applyStimulus(1'b0, 4'b0000, 1'b1);
      checkOutput("drain_ready", N'(in_ready), N'(0));
      clockCycle();
      checkOutput("drain_valid", N'(out_valid), N'(0));
      checkOutput("drain_data", out_data, dWord[2]);
      checkOutput("drain_sel", N'(out_sel), N'(2));

      // Reset mid-stream with a stalled word; pointer is 3 beforehand
      applyStimulus(1'b0, 4'b0100, 1'b1);
      clockCycle();
      checkOutput("mid_loaded", N'(out_valid), N'(1));
      applyStimulus(1'b0, 4'b0000, 1'b0);
      rst_n = 1'b0;
      #1;
      checkOutput("mid_async_valid", N'(out_valid), N'(0));
      checkOutput("mid_async_data", out_data, N'(0));
      clockCycle();
      rst_n = 1'b1;
      applyStimulus(1'b0, 4'b1111, 1'b1);
      checkOutput("mid_restart_ready", N'(in_ready), N'(4'b0001));
      clockCycle();
      checkOutput("mid_restart_sel", N'(out_sel), N'(0));
      checkOutput("mid_restart_data", out_data, dWord[0]);

      $display("== %0d vectors applied, %0d miscompares ==", numChecks, numErrors);
      $finish;
   end

endmodule

// File: doc/mux_rr_n.md
# mux_rr_n

Registered N-channel arbitrating multiplexer with a valid/ready handshake on every port. It is the next generation of the team's plain two-input word mux. Each cycle it selects one requesting input channel, using either round-robin or fixed priority, and captures that channel's word into a single output register. It sits between multiple bloom-filter hash/query producers and a shared downstream consumer such as the bit-array access port.

## Interface
Parameters:
- N, 32, data word width in bits (≥1)
- CH, 4, number of input channels (≥2)
- SELW, 2, width of the channel index; must equal clog2(CH)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst_n  input  1  reset, asynchronous and active-low
- fixed_pri  input  1  1 = fixed priority (lowest index wins); 0 = round-robin
- in_valid  input  CH  per-channel request
- in_data  input  CH*N  channel c occupies bits [c*N +: N]
- in_ready  output  CH  per-channel accept; at most one bit set (one-hot or zero)
- out_valid  output  1  output register holds a word
- out_data  output  N  registered word
- out_sel  output  SELW  index of the channel that supplied out_data
- out_ready  input  1  consumer accepts out_data when out_valid && out_ready

## Operation
- Load enable: ld = !out_valid || out_ready.
- Grant:
  - Computed combinationally from in_valid, fixed_pri and the round-robin pointer ptr (SELW bits).
  - fixed_pri=1: the lowest-index channel with in_valid set.
  - fixed_pri=0: the first channel with in_valid set, searching from ptr upward and wrapping CH-1→0.
- in_ready[g] = ld && in_valid[g] for the granted channel g only; all other bits are 0. A transfer on channel c occurs when in_valid[c] && in_ready[c].
- On a transfer:
  - out_data ← in_data[g*N +: N], out_sel ← g, out_valid ← 1.
  - ptr ← g+1, wrapping to 0 when g = CH-1.
  - ptr advances in both modes, so a mode change mid-stream is well defined.
- ld=1 with no in_valid: out_valid ← 0; out_data and out_sel hold their old values.
- ld=0 (out_valid && !out_ready): out_valid, out_data, out_sel and ptr all hold; in_ready = 0.
- Arbitration is fair in round-robin mode. With all channels requesting continuously and out_ready=1, the grant order is 0,1,…,CH-1,0,…
- Inputs must hold in_data stable while in_valid=1 and the channel is not yet granted. The block does not check this.
- Reset values (async assert on rst_n low): out_valid=0, out_data=0, out_sel=0, ptr=0. in_ready is 0 while rst_n is low.
- Reset mid-operation: any word in the output register is discarded without handshake. After release, arbitration restarts with channel 0 highest priority.

## Timing
- Latency: 1 cycle from the input transfer edge to out_valid/out_data.
- Throughput: one word per cycle while out_ready=1 and any in_valid=1.
- in_ready has a combinational path from in_valid, out_ready and fixed_pri. No combinational path exists from in_data to any output.
- Simultaneous output drain and input load in one cycle are legal. The new word replaces the old one at the same edge with no bubble.
- rst_n deassertion is expected synchronous to clk (external synchroniser). Outputs are registered only and are glitch-free except in_ready.

## Test plan
- Reset: hold rst_n=0 with random inputs -> out_valid=0, out_data=0, out_sel=0, in_ready=0; first grant after release with in_valid=4'b1111, fixed_pri=0 is channel 0.
- Round-robin fairness: CH=4, in_valid=4'b1111, in_data={D3,D2,D1,D0}, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3 with matching data, one word per cycle.
- Fixed priority and pointer wrap: fixed_pri=1 with in_valid=4'b1010 -> out_sel=1 every cycle; then switch to fixed_pri=0 -> next grant is 3, then 1.
- Backpressure: out_valid=1 with out_data=0xDEADBEEF, out_ready=0 for 5 cycles, in_valid=4'b0100 -> out_data, out_sel=0 and in_ready=0 stable throughout; raise out_ready -> same-cycle reload with channel 2 and in_ready=4'b0100.
- Drain to empty: single word accepted, then in_valid=0 and out_ready=1 -> out_valid falls the next cycle, out_data retains its last value.
- Reset mid-stream: assert rst_n low while out_valid=1 and out_ready=0 -> out_valid=0 immediately (async); the word is never delivered.
